// File: rtl/regfile_write_buffer_if.sv
// rtl/regfile_write_buffer_if.sv - enqueue handshake bundle for the register write buffer
interface regfile_write_buffer_if;
  logic        InValid;
  logic        InReady;
  logic [4:0]  InRegister;
  logic [31:0] InData;

  modport master (
    output InValid,
    output InRegister,
    output InData,
    input  InReady
  );

  modport slave (
    input  InValid,
    input  InRegister,
    input  InData,
    output InReady
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// rtl/regfile_write_buffer.sv - in-order write FIFO in front of the 32x32 register file with read bypass
module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  regfile_write_buffer_if.slave in_if,
  input  logic                 Stall,
  output logic                 RegWrite,
  output logic [4:0]           WriteRegister,
  output logic [31:0]          WriteData,
  input  logic [4:0]           ReadRegister1,
  input  logic [4:0]           ReadRegister2,
  output logic                 BypassHit1,
  output logic [31:0]          BypassData1,
  output logic                 BypassHit2,
  output logic [31:0]          BypassData2,
  output logic [PTRW:0]        Count,
  output logic                 Empty
);

  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
  localparam logic [PTRW:0]   CNT_FULL = (PTRW+1)'(DEPTH);

  logic [4:0]      r_addr [DEPTH];
  logic [31:0]     r_data [DEPTH];
  logic [PTRW-1:0] r_head;
  logic [PTRW-1:0] r_tail;
  logic [PTRW:0]   r_count;

  logic            w_empty;
  logic            w_ready;
  logic            w_enq;
  logic            w_deq;
  logic [PTRW-1:0] w_idx;
  logic            w_hit1;
  logic            w_hit2;
  logic [31:0]     w_bdata1;
  logic [31:0]     w_bdata2;

  // Ready depends only on occupancy so a full buffer never accepts while draining.
  assign w_empty = (r_count == '0);
  assign w_ready = (r_count != CNT_FULL);
  // Writes to r0 complete the handshake but are dropped, since r0 is hardwired to zero.
  assign w_enq   = in_if.InValid && w_ready && (in_if.InRegister != 5'd0);
  assign w_deq   = !w_empty && !Stall;

  assign in_if.InReady = w_ready;
  assign RegWrite      = w_deq;
  assign WriteRegister = w_empty ? 5'd0  : r_addr[r_head];
  assign WriteData     = w_empty ? 32'd0 : r_data[r_head];
  assign Count         = r_count;
  assign Empty         = w_empty;
  assign BypassHit1    = w_hit1;
  assign BypassData1   = w_bdata1;
  assign BypassHit2    = w_hit2;
  assign BypassData2   = w_bdata2;

  // Walk occupied entries oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    w_idx    = '0;
    w_hit1   = 1'b0;
    w_hit2   = 1'b0;
    w_bdata1 = 32'd0;
    w_bdata2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTRW'(i);
      if ((PTRW+1)'(i) < r_count) begin
        if ((ReadRegister1 != 5'd0) && (r_addr[w_idx] == ReadRegister1)) begin
          w_hit1   = 1'b1;
          w_bdata1 = r_data[w_idx];
        end
        if ((ReadRegister2 != 5'd0) && (r_addr[w_idx] == ReadRegister2)) begin
          w_hit2   = 1'b1;
          w_bdata2 = r_data[w_idx];
        end
      end
    end
  end

  // FIFO storage, pointers and occupancy; reset discards every queued write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= 5'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_tail] <= in_if.InRegister;
        r_data[r_tail] <= in_if.InData;
        r_tail         <= r_tail + PTR_ONE;
      end
      if (w_deq) begin
        r_head <= r_head + PTR_ONE;
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_enq && w_deq) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule
